decoder_seq: RTL and testbench

Parametrised, registered successor to the team's one-hot 3-to-8 decoder. Accepts a select code over a valid/ready handshake and drives a 2^SEL_W-bit one-hot output bus in one of three modes: latched level, timed pulse, or timed scan that walks every output with wrap-around. Sits between control FSMs and row/strobe/chip-select fan-out logic that needs timed one-hot activation rather than a purely combinational decode.

---
 rtl/decoder_seq_pkg.sv | 17 +
 rtl/decoder_seq_if.sv | 24 ++
 rtl/decoder_seq_onehot_dec.sv | 14 +
 rtl/decoder_seq.sv | 119 +++++++++++
 tb/tb_decoder_seq.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/decoder_seq_pkg.sv
// Shared types for the sequenced one-hot decoder family.
package decoder_pkg;

  typedef enum logic [1:0] {
    LEVEL = 2'b00,
    PULSE = 2'b01,
    SCAN  = 2'b10,
    RSVD  = 2'b11
  } mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    LATCH = 2'b01,
    RUN   = 2'b10
  } state_e;

endpackage

// File: rtl/decoder_seq_if.sv
// Request/response bundle between a control FSM and decoder_seq.
interface decoder_seq_if #(
  parameter int SEL_W  = 3,
  parameter int HOLD_W = 8
) ();
  logic                  in_valid;
  logic                  in_ready;
  logic [SEL_W-1:0]      sel;
  logic [1:0]            mode;
  logic [HOLD_W-1:0]     hold;
  logic [2**SEL_W-1:0]   Y;
  logic                  busy;
  logic                  done;

  modport master (
    output in_valid, sel, mode, hold,
    input  in_ready, Y, busy, done
  );

  modport slave (
    input  in_valid, sel, mode, hold,
    output in_ready, Y, busy, done
  );
endinterface

// File: rtl/decoder_seq_onehot_dec.sv
// Combinational index to one-hot decode, reusable by other decoders.
module onehot_dec #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]    i_idx,
  output logic [2**SEL_W-1:0] o_y
);

  always_comb begin
    o_y        = '0;
    o_y[i_idx] = 1'b1;
  end

endmodule

// File: rtl/decoder_seq.sv
// Registered one-hot decoder with latched level, timed pulse and timed scan modes.
module decoder_seq
  import decoder_pkg::*;
#(
  parameter int SEL_W  = 3,
  parameter int HOLD_W = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  decoder_seq_if.slave  bus
);

  localparam int             OUT_W     = 2**SEL_W;
  localparam logic [SEL_W:0] STEPS_ONE  = (SEL_W+1)'(1);
  localparam logic [SEL_W:0] STEPS_SCAN = (SEL_W+1)'(OUT_W);

  state_e              r_state, w_nState;
  logic [SEL_W-1:0]    r_pos, w_nPos;
  logic [HOLD_W-1:0]   r_dwell, w_nDwell;
  logic [HOLD_W-1:0]   r_hold, w_nHold;
  logic [SEL_W:0]      r_steps, w_nSteps;
  logic                r_done, w_nDone;
  logic                r_live;
  logic [OUT_W-1:0]    r_y;
  logic [OUT_W-1:0]    w_dec;
  logic                w_ready;
  logic                w_accept;
  logic                w_active;
  mode_e               w_mode;

  assign w_mode   = mode_e'(bus.mode);
  assign w_ready  = en && r_live && (r_state != RUN);
  assign w_accept = bus.in_valid && w_ready;

  // A run ends once the dwell is spent on its last remaining step.
  always_comb begin
    w_nState = r_state;
    w_nPos   = r_pos;
    w_nDwell = r_dwell;
    w_nHold  = r_hold;
    w_nSteps = r_steps;
    w_nDone  = 1'b0;

    if (!en) begin
      w_nState = IDLE;
      w_nPos   = '0;
      w_nDwell = '0;
      w_nHold  = '0;
      w_nSteps = '0;
    end else if (w_accept) begin
      w_nPos   = bus.sel;
      w_nHold  = bus.hold;
      w_nDwell = bus.hold;
      case (w_mode)
        PULSE: begin
          w_nState = RUN;
          w_nSteps = STEPS_ONE;
        end
        SCAN: begin
          w_nState = RUN;
          w_nSteps = STEPS_SCAN;
        end
        default: begin
          w_nState = LATCH;
          w_nSteps = '0;
        end
      endcase
    end else if (r_state == RUN) begin
      if (r_dwell != '0) begin
        w_nDwell = r_dwell - 1'b1;
      end else if (r_steps == STEPS_ONE) begin
        w_nState = IDLE;
        w_nSteps = '0;
        w_nDone  = 1'b1;
      end else begin
        w_nPos   = r_pos + 1'b1;
        w_nDwell = r_hold;
        w_nSteps = r_steps - 1'b1;
      end
    end
  end

  assign w_active = (w_nState != IDLE);

  onehot_dec #(.SEL_W(SEL_W)) u_dec (
    .i_idx (w_nPos),
    .o_y   (w_dec)
  );

  // Y is decoded from the next position so it lands in the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_pos   <= '0;
      r_dwell <= '0;
      r_hold  <= '0;
      r_steps <= '0;
      r_done  <= 1'b0;
      r_live  <= 1'b0;
      r_y     <= '0;
    end else begin
      r_state <= w_nState;
      r_pos   <= w_nPos;
      r_dwell <= w_nDwell;
      r_hold  <= w_nHold;
      r_steps <= w_nSteps;
      r_done  <= w_nDone;
      r_live  <= 1'b1;
      r_y     <= w_active ? w_dec : '0;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.Y        = r_y;
  assign bus.busy     = (r_state == RUN);
  assign bus.done     = r_done;

endmodule

// File: tb/tb_decoder_seq.sv
// Self-checking bench for decoder_seq against a queue-based expected-output model.
module tb_decoder_seq;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic en    = 1'b0;

  always #5 clk = ~clk;

  decoder_seq_if #(.SEL_W(3), .HOLD_W(8)) bi ();
  decoder_seq_if #(.SEL_W(3), .HOLD_W(4)) bh ();
  decoder_seq_if #(.SEL_W(1), .HOLD_W(8)) bs ();

  decoder_seq #(.SEL_W(3), .HOLD_W(8)) dut     (.clk(clk), .rst_n(rst_n), .en(en), .bus(bi));
  decoder_seq #(.SEL_W(3), .HOLD_W(4)) dut_h4  (.clk(clk), .rst_n(rst_n), .en(en), .bus(bh));
  decoder_seq #(.SEL_W(1), .HOLD_W(8)) dut_s1  (.clk(clk), .rst_n(rst_n), .en(en), .bus(bs));

  int checks   = 0;
  int failures = 0;
  int unsigned expQ[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected Y per active cycle: each visited position held for hold+1 cycles.
  task automatic buildExpect(input int m, input int s, input int h, input int outW);
    expQ.delete();
    if (m == 1) begin
      for (int c = 0; c <= h; c++) expQ.push_back(32'd1 << s);
    end else begin
      for (int p = 0; p < outW; p++)
        for (int c = 0; c <= h; c++) expQ.push_back(32'd1 << ((s + p) % outW));
    end
  endtask

  task automatic applyStimulus(input int m, input int s, input int h, input bit keepValid);
    bi.in_valid = 1'b1;
    bi.mode     = 2'(m);
    bi.sel      = 3'(s);
    bi.hold     = 8'(h);
    tick();
    if (!keepValid) bi.in_valid = 1'b0;
  endtask

  task automatic checkOutput(input int m, input int s, input int h, input string tag);
    buildExpect(m, s, h, 8);
    for (int i = 0; i < expQ.size(); i++) begin
      check($sformatf("%s.y%0d", tag, i), bi.Y, expQ[i]);
      check($sformatf("%s.busy%0d", tag, i), bi.busy, 1);
      check($sformatf("%s.done%0d", tag, i), bi.done, 0);
      check($sformatf("%s.rdy%0d", tag, i), bi.in_ready, 0);
      tick();
    end
    check({tag, ".endY"}, bi.Y, 0);
    check({tag, ".endDone"}, bi.done, 1);
    check({tag, ".endBusy"}, bi.busy, 0);
    check({tag, ".endRdy"}, bi.in_ready, 1);
  endtask

  initial begin
    int s, h, m, cnt;
    bit sawDone;

    bi.in_valid = 1'b0; bi.sel = '0; bi.mode = '0; bi.hold = '0;
    bh.in_valid = 1'b0; bh.sel = '0; bh.mode = '0; bh.hold = '0;
    bs.in_valid = 1'b0; bs.sel = '0; bs.mode = '0; bs.hold = '0;
    en = 1'b1;

    #12;
    check("rst.Y", bi.Y, 0);
    check("rst.busy", bi.busy, 0);
    check("rst.done", bi.done, 0);
    check("rst.rdy", bi.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel.rdyBeforeEdge", bi.in_ready, 0);
    tick();
    check("rel.rdy", bi.in_ready, 1);

    h = $urandom_range(0, 255);
    applyStimulus(0, 5, h, 0);
    for (int i = 0; i < 20; i++) begin
      check($sformatf("lvl5.y%0d", i), bi.Y, 32'h20);
      check($sformatf("lvl5.done%0d", i), bi.done, 0);
      check($sformatf("lvl5.busy%0d", i), bi.busy, 0);
      tick();
    end
    applyStimulus(0, 2, h, 0);
    check("lvl2.y", bi.Y, 32'h04);
    check("lvl2.rdy", bi.in_ready, 1);

    applyStimulus(1, 7, 3, 1);
    checkOutput(1, 7, 3, "pulse7");
    bi.in_valid = 1'b0;
    tick();
    check("pulse7.idleY", bi.Y, 0);
    check("pulse7.idleDone", bi.done, 0);

    applyStimulus(2, 6, 0, 0);
    checkOutput(2, 6, 0, "scan6");
    s = $urandom_range(0, 7);
    h = $urandom_range(0, 5);
    applyStimulus(1, s, h, 0);
    checkOutput(1, s, h, "b2bPulse");

    for (int k = 0; k < 8; k++) begin
      m = $urandom_range(0, 3);
      s = $urandom_range(0, 7);
      h = $urandom_range(0, 3);
      applyStimulus(m, s, h, 0);
      if (m == 0 || m == 3) begin
        for (int i = 0; i < 3; i++) begin
          check($sformatf("rnd%0d.lvlY%0d", k, i), bi.Y, 32'd1 << s);
          check($sformatf("rnd%0d.lvlDone%0d", k, i), bi.done, 0);
          tick();
        end
      end else begin
        checkOutput(m, s, h, $sformatf("rnd%0d", k));
      end
    end

    applyStimulus(2, 0, 2, 0);
    buildExpect(2, 0, 2, 8);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("abort.y%0d", i), bi.Y, expQ[i]);
      tick();
    end
    check("abort.y4", bi.Y, expQ[4]);
    en = 1'b0;
    tick();
    check("abort.Y", bi.Y, 0);
    check("abort.busy", bi.busy, 0);
    check("abort.done", bi.done, 0);
    check("abort.rdy", bi.in_ready, 0);
    en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("abort.noDone%0d", i), bi.done, 0);
      check($sformatf("abort.zeroY%0d", i), bi.Y, 0);
    end

    s = $urandom_range(0, 7);
    bh.in_valid = 1'b1; bh.mode = 2'd1; bh.sel = 3'(s); bh.hold = 4'hF;
    tick();
    bh.in_valid = 1'b0;
    check("h4.firstY", bh.Y, 32'd1 << s);
    cnt = 0;
    sawDone = 1'b0;
    for (int i = 0; i < 40 && !sawDone; i++) begin
      if (bh.Y != '0) cnt++;
      if (bh.done) sawDone = 1'b1;
      else tick();
    end
    check("h4.activeCycles", cnt, 16);
    check("h4.sawDone", sawDone, 1);
    check("h4.doneY", bh.Y, 0);

    bs.in_valid = 1'b1; bs.mode = 2'd2; bs.sel = 1'b1; bs.hold = 8'd0;
    tick();
    bs.in_valid = 1'b0;
    check("s1.y0", bs.Y, 2);
    check("s1.busy0", bs.busy, 1);
    tick();
    check("s1.y1", bs.Y, 1);
    check("s1.done1", bs.done, 0);
    tick();
    check("s1.endY", bs.Y, 0);
    check("s1.endDone", bs.done, 1);

    s = $urandom_range(0, 7);
    applyStimulus(2, s, 1, 0);
    tick();
    tick();
    check("arst.preY", bi.Y, 32'd1 << ((s + 1) % 8));
    #2;
    rst_n = 1'b0;
    #1;
    check("arst.Y", bi.Y, 0);
    check("arst.busy", bi.busy, 0);
    check("arst.done", bi.done, 0);
    check("arst.rdy", bi.in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("arst.rdyBeforeEdge", bi.in_ready, 0);
    tick();
    check("arst.rdy", bi.in_ready, 1);
    check("arst.postY", bi.Y, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
